// File: rtl/signed_tick_counter_pkg.sv
// Shared constants and helpers for the signed tick counter slice.
package signed_tick_counter_pkg;

   // Default counter width (two's complement).
   localparam int WIDTH_DEFAULT = 8;

   // Divide-by-3 phase encoding.
   localparam logic [1:0] PH0 = 2'd0;
   localparam logic [1:0] PH1 = 2'd1;
   localparam logic [1:0] PH2 = 2'd2;

   // Number of clock cycles per prescaler tick.
   function automatic int prescale_of(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   // Bit width needed to hold a prescaler count of 0..PRESCALE-1.
   function automatic int prescale_width(input int clk_hz, input int tick_hz);
      int p;
      p = clk_hz / tick_hz;
      return (p < 2) ? 1 : $clog2(p);
   endfunction

endpackage

// File: rtl/signed_tick_counter_button_debouncer.sv
// Raw pushbutton -> 2-flop synchroniser -> debounce counter -> one-cycle
// press pulse on each accepted rising level. Releases are accepted
// silently.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int             CW       = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          level;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser for the asynchronous button input.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
      end
   end

   // Accept a new level only after it has differed from the accepted level
   // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_q2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_q2;
            cnt   <= '0;
            press <= sync_q2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/signed_tick_counter.sv
// Signed WIDTH-bit counter feeding the seven-segment display stage.
// Auto-steps on every third prescaler tick while running; debounced
// buttons step up, step down or clear it. All arithmetic wraps.
module signed_tick_counter
   import signed_tick_counter_pkg::*;
#(
   parameter int CLK_HZ          = 100000000,
   parameter int TICK_HZ         = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int WIDTH           = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_clear,
   input  logic             sw_run,
   input  logic             sw_dir,
   output logic [WIDTH-1:0] value,
   output logic             tick,
   output logic             step
);

   localparam int               PRESCALE  = prescale_of(CLK_HZ, TICK_HZ);
   localparam int               PW        = prescale_width(CLK_HZ, TICK_HZ);
   localparam logic [PW-1:0]    PS_LAST   = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   localparam logic [WIDTH-1:0] MINUS_ONE = '1;

   logic             run_q1, run_q2;
   logic             dir_q1, dir_q2;
   logic             up_p, down_p, clear_p;
   logic [PW-1:0]    pcount;
   logic [1:0]       phase;
   logic             auto_step;
   logic [WIDTH-1:0] delta;
   logic [WIDTH-1:0] value_next;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_up),
      .press (up_p)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_down),
      .press (down_p)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_clear),
      .press (clear_p)
   );

   // Switches are level controls: synchronised only, never debounced.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_q1 <= 1'b0;
         run_q2 <= 1'b0;
         dir_q1 <= 1'b0;
         dir_q2 <= 1'b0;
      end else begin
         run_q1 <= sw_run;
         run_q2 <= run_q1;
         dir_q1 <= sw_dir;
         dir_q2 <= dir_q1;
      end
   end

   // Combined increment: manual +/-1 (up and down cancel) plus auto-step.
   always_comb begin
      auto_step = tick && (phase == PH2);
      delta     = '0;
      if (up_p && !down_p) begin
         delta = ONE;
      end else if (down_p && !up_p) begin
         delta = MINUS_ONE;
      end
      if (auto_step) begin
         delta = delta + (dir_q2 ? MINUS_ONE : ONE);
      end
      value_next = value + delta;
   end

   // Prescaler: counts only while running; a clear restarts it and drops
   // any tick that would have been raised on the same edge.
   always_ff @(posedge clk) begin
      if (reset || clear_p) begin
         pcount <= '0;
         tick   <= 1'b0;
      end else begin
         tick <= run_q2 && (pcount == PS_LAST);
         if (run_q2) begin
            pcount <= (pcount == PS_LAST) ? '0 : pcount + 1'b1;
         end
      end
   end

   // Phase, value and step pulse; clear has priority and discards any
   // auto-step landing on the same cycle.
   always_ff @(posedge clk) begin
      if (reset || clear_p) begin
         phase <= PH0;
         value <= '0;
         step  <= 1'b0;
      end else begin
         step  <= auto_step;
         value <= value_next;
         if (tick) begin
            case (phase)
               PH0:     phase <= PH1;
               PH1:     phase <= PH2;
               default: phase <= PH0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_signed_tick_counter.sv
// Directed bench for signed_tick_counter with PRESCALE=12, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Edge counts below are relative to the moment an input is changed.
module tb_signed_tick_counter;

   localparam int CLK_HZ  = 12;
   localparam int TICK_HZ = 1;
   localparam int DEB     = 4;
   localparam int W       = 8;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_CLEAR = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         btn_up = 1'b0;
   logic         btn_down = 1'b0;
   logic         btn_clear = 1'b0;
   logic         sw_run = 1'b0;
   logic         sw_dir = 1'b0;
   logic [W-1:0] value;
   logic         tick;
   logic         step;

   int checks   = 0;
   int failures = 0;

   signed_tick_counter #(
      .CLK_HZ          (CLK_HZ),
      .TICK_HZ         (TICK_HZ),
      .DEBOUNCE_CYCLES (DEB),
      .WIDTH           (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_clear (btn_clear),
      .sw_run    (sw_run),
      .sw_dir    (sw_dir),
      .value     (value),
      .tick      (tick),
      .step      (step)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      btn_up    = 1'b0;
      btn_down  = 1'b0;
      btn_clear = 1'b0;
      sw_run    = 1'b0;
      sw_dir    = 1'b0;
      cyc(2);
      reset = 1'b0;
   endtask

   // Driver tasks
   task automatic set_btn(input int which, input logic lv);
      case (which)
         BTN_UP:   btn_up    = lv;
         BTN_DOWN: btn_down  = lv;
         default:  btn_clear = lv;
      endcase
   endtask

   // Press and release n times; 8 cycles each side covers the 2+4 cycle
   // acceptance latency.
   task automatic press(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         set_btn(which, 1'b1);
         cyc(8);
         set_btn(which, 1'b0);
         cyc(8);
      end
   endtask

   // Advance until step is seen (at least one edge), bounded by budget.
   task automatic wait_step(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (step !== 1'b1 && n < budget);
      check(tag, {31'd0, step}, 32'd1);
   endtask

   initial begin
      // ---------------- reset state ----------------
      apply_reset();
      check("reset_value", {24'd0, value}, 32'h00);
      check("reset_tick",  {31'd0, tick},  32'd0);
      check("reset_step",  {31'd0, step},  32'd0);

      // ---------------- free run, dir up ----------------
      // run seen after 2 edges; count 0..11 over edges 3..13; tick after
      // edges 14, 26, 38; third tick has phase 2 -> value/step after 39.
      sw_run = 1'b1;
      cyc(14);
      check("run_tick1",      {31'd0, tick},  32'd1);
      check("run_tick1_step", {31'd0, step},  32'd0);
      cyc(1);
      check("run_tick_width", {31'd0, tick},  32'd0);
      cyc(24);
      check("run_value1",     {24'd0, value}, 32'h01);
      check("run_step1",      {31'd0, step},  32'd1);
      cyc(1);
      check("run_step_width", {31'd0, step},  32'd0);
      cyc(35);
      check("run_value2",     {24'd0, value}, 32'h02);
      check("run_step2",      {31'd0, step},  32'd1);

      // ---------------- wrap 127 -> -128 -> 127 ----------------
      apply_reset();
      press(BTN_UP, 126);
      check("preload_126", {24'd0, value}, 32'h7E);
      sw_run = 1'b1;
      wait_step("wrap_step_a", 60);
      check("wrap_127",    {24'd0, value}, 32'h7F);
      wait_step("wrap_step_b", 60);
      check("wrap_m128",   {24'd0, value}, 32'h80);
      sw_dir = 1'b1;
      wait_step("wrap_step_c", 60);
      check("wrap_back_127", {24'd0, value}, 32'h7F);

      // ---------------- bounce rejection ----------------
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         btn_up = 1'b1;
         cyc(2);
         btn_up = 1'b0;
         cyc(2);
      end
      cyc(4);
      check("bounce_no_change", {24'd0, value}, 32'h00);
      btn_up = 1'b1;
      cyc(6);
      check("bounce_held_wait", {24'd0, value}, 32'h00);
      cyc(1);
      check("bounce_accept",    {24'd0, value}, 32'h01);
      btn_up = 1'b0;
      cyc(10);
      check("bounce_release",   {24'd0, value}, 32'h01);

      // ---------------- clear vs auto-step ----------------
      // Auto-step cycle is after edge 38; clear pulse lands there when the
      // button goes high 6 edges earlier (after edge 32).
      apply_reset();
      press(BTN_UP, 5);
      check("clear_preload", {24'd0, value}, 32'h05);
      sw_run = 1'b1;
      cyc(32);
      btn_clear = 1'b1;
      cyc(6);
      check("clear_coincide_tick", {31'd0, tick},  32'd1);
      cyc(1);
      check("clear_value",         {24'd0, value}, 32'h00);
      check("clear_step_dropped",  {31'd0, step},  32'd0);
      btn_clear = 1'b0;
      // Prescaler restarts at 0: ticks after +12, +24, +36; the phase-2
      // tick is 36 edges after the clear edge, value updates one later.
      cyc(36);
      check("clear_next_tick",  {31'd0, tick},  32'd1);
      check("clear_hold_value", {24'd0, value}, 32'h00);
      cyc(1);
      check("clear_next_value", {24'd0, value}, 32'h01);
      check("clear_next_step",  {31'd0, step},  32'd1);

      // ---------------- up+down cancel, up + auto-step ----------------
      apply_reset();
      press(BTN_DOWN, 3);
      check("cancel_preload", {24'd0, value}, 32'hFD);
      btn_up   = 1'b1;
      btn_down = 1'b1;
      cyc(8);
      check("cancel_value", {24'd0, value}, 32'hFD);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      cyc(8);
      check("cancel_release", {24'd0, value}, 32'hFD);
      sw_run = 1'b1;
      cyc(32);
      btn_up = 1'b1;
      cyc(6);
      check("sum_tick",  {31'd0, tick},  32'd1);
      check("sum_before",{24'd0, value}, 32'hFD);
      cyc(1);
      check("sum_value", {24'd0, value}, 32'hFF);
      check("sum_step",  {31'd0, step},  32'd1);
      btn_up = 1'b0;
      cyc(8);

      // ---------------- mid-operation reset ----------------
      apply_reset();
      press(BTN_UP, 40);
      check("midrst_preload", {24'd0, value}, 32'h28);
      sw_run = 1'b1;
      cyc(20);
      btn_up = 1'b1;
      cyc(3);
      check("midrst_before", {24'd0, value}, 32'h28);
      reset  = 1'b1;
      sw_run = 1'b0;
      cyc(1);
      check("midrst_value", {24'd0, value}, 32'h00);
      check("midrst_tick",  {31'd0, tick},  32'd0);
      check("midrst_step",  {31'd0, step},  32'd0);
      reset = 1'b0;
      cyc(6);
      check("midrst_wait",  {24'd0, value}, 32'h00);
      cyc(1);
      check("midrst_press", {24'd0, value}, 32'h01);
      cyc(10);
      check("midrst_once",  {24'd0, value}, 32'h01);
      btn_up = 1'b0;
      cyc(8);

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/signed_tick_counter.md
Name: signed_tick_counter

Overview:
- Upstream value source for the 8-bit signed seven-segment display stage; drives its `value` input directly.
- Free-running divide-by-3 signed counter: advances one step on every third prescaler tick while running.
- Manual control by debounced buttons: step up, step down, clear.
- Synchronised switches select run/hold and count direction.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 3, prescaler tick rate in Hz. PRESCALE = CLK_HZ/TICK_HZ, which must be ≥2.
- DEBOUNCE_CYCLES, 1000000, clock cycles an input must hold a new level before it is accepted (10 ms at 100 MHz). Must be ≥2.
- WIDTH, 8, counter width. Two's complement.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- btn_up  in  1  raw pushbutton: step +1.
- btn_down  in  1  raw pushbutton: step −1.
- btn_clear  in  1  raw pushbutton: clear to 0.
- sw_run  in  1  raw switch: 1 = auto-count, 0 = hold.
- sw_dir  in  1  raw switch: 0 = auto-count up, 1 = auto-count down.
- value  out  WIDTH  current signed count, to the display stage.
- tick  out  1  one-cycle pulse per prescaler period (debug/LED).
- step  out  1  one-cycle pulse when an auto-step is applied (every third tick).

Behaviour:
- Reset is synchronous and active-high on clk; there is one clock. In the cycle after reset is sampled high:
  - value=0, tick=0, step=0;
  - prescaler count=0, phase=0;
  - all synchroniser flops=0;
  - debounced levels=0, debounce counters=0.
- Input synchronisation:
  - All five raw inputs pass through 2-flop synchronisers, giving 2 cycles of latency.
  - Switches are used after synchronisation only; they are not debounced.
- Debounce, per button:
  - s is the synchronised level; d is the accepted level (reset 0).
  - If s==d, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES−1, then d<=s, cnt<=0, and the press pulse p<=s.
  - Else cnt<=cnt+1.
  - p is high exactly one cycle per accepted 0→1 transition. Release produces no pulse.
  - Any bounce shorter than DEBOUNCE_CYCLES restarts the count.
  - A button held through reset release is accepted after DEBOUNCE_CYCLES and then pulses once.
- Prescaler:
  - Runs only while synchronised run=1; holds its count while run=0.
  - Counts 0..PRESCALE−1 and wraps to 0.
  - tick is registered and is high in the cycle after the count equals PRESCALE−1.
- Divide-by-3 phase:
  - On each tick, phase advances 0→1→2→0.
  - When tick is high and phase==2, auto_step is high in that cycle and the step output is registered from it.
- Value update priority, evaluated per cycle, highest first:
  1. clear_p: value<=0, phase<=0, prescaler<=0. Any auto-step in the same cycle is discarded.
  2. up_p and down_p together: they cancel. value is unchanged; auto-step is still applied if present.
  3. Manual ±1 and auto-step in the same cycle: both are applied as a single sum, e.g. +1 plus auto −1 gives unchanged.
  4. Auto-step alone: value<=value+1 if dir=0, value−1 if dir=1.
- Arithmetic:
  - WIDTH-bit modular arithmetic; the count wraps, never saturates.
  - 127+1 gives −128 (0x80); −128−1 gives 127 (0x7F).
- Latency:
  - Button press pulse to value change: 1 cycle.
  - Auto-step pulse and value change: same registered edge. value updates on the cycle tick is high with phase==2, and step is high in the following cycle.
- value is a registered output. It is glitch-free and safe for a downstream combinational decode.
- Mid-operation reset: all state returns to reset values in one cycle, and any in-progress debounce is discarded.
- Changing dir while run=1 affects only the next step; the phase is kept.

Decomposition:
- Shared package:
  - WIDTH default;
  - phase encoding constants PH0/PH1/PH2 (2-bit);
  - a function for PRESCALE computation with a width via $clog2.
- One natural sub-module, button_debouncer (synchroniser + debounce counter + rise pulse):
  - instantiated three times for the buttons;
  - sw_run and sw_dir use plain 2-flop synchronisers inline.

Test Plan (CLK_HZ=12, TICK_HZ=1 → PRESCALE=12; DEBOUNCE_CYCLES=4):
- Reset then run=1, dir=0 → tick every 12 cycles, step every 36 cycles; value 0→1→2 after 36 and 72 cycles; step pulses are 1 cycle wide.
- Preload value=126 via up presses, run=1, dir=0 → value reaches 127 then 0x80 (−128); dir=1 from −128 gives 127.
- btn_up bounces 1-0-1-0 with 2-cycle pulses, then holds → no change until held 4 cycles after sync; then exactly one +1; release causes no change.
- btn_clear accepted in the same cycle as an auto-step with value=5 → value=0, phase=0, prescaler restarts; next step occurs 36 cycles later.
- up and down accepted in the same cycle with value=−3 → value stays −3; up accepted together with an auto-step (dir=0) → value=−1.
- Reset asserted mid-debounce and mid-prescale with value=40 → next cycle value=0, tick=0, step=0; a held button yields one pulse 2+4 cycles after reset release.
